fighter_controller: RTL



---
 rtl/fighter_pkg.sv | 34 +++
 rtl/combo_detector.sv | 70 +++++++
 rtl/fighter_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared encodings and screen geometry for the per-player fighter controller.
package fighter_pkg;

  typedef enum logic [2:0] {
    STATE_NORMAL  = 3'b000,
    STATE_PUNCH   = 3'b001,
    STATE_SP_0    = 3'b010,
    STATE_INJURED = 3'b100
  } char_state_t;

  typedef enum logic [1:0] {
    MOVE_IDLE = 2'b00,
    MOVE_FWD  = 2'b01,
    MOVE_BACK = 2'b10
  } move_t;

  typedef enum logic [1:0] {
    COMBO_IDLE,
    COMBO_L,
    COMBO_LD,
    COMBO_LDR
  } combo_t;

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;
  localparam int X_CENTRE = SCREEN_W / 2;
  localparam int Y_CENTRE = SCREEN_H / 2;

  // Moving right while facing right (or left while facing left) is forward.
  function automatic move_t walk_dir(input logic go_right, input logic facing_left);
    return (go_right ^ facing_left) ? MOVE_FWD : MOVE_BACK;
  endfunction

endpackage

// File: rtl/combo_detector.sv
// Recognises left>down>right>attack within a tick window; latches special/attack requests until the next tick.
// Latency: edges are registered in one clk; requests are visible combinationally in the same clk.
module combo_detector
  import fighter_pkg::*;
#(
  parameter int COMBO_WINDOW = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic left_edge,
  input  logic down_edge,
  input  logic right_edge,
  input  logic attack_edge,
  output logic special_fire,
  output logic attack_fire
);

  localparam int WW = $clog2(COMBO_WINDOW + 2);

  combo_t          state, state_next;
  logic [WW-1:0]   win, win_next;
  logic            sf_q, atk_q, fire_now;

  assign fire_now     = attack_edge && (state == COMBO_LDR);
  assign special_fire = sf_q | fire_now;
  assign attack_fire  = atk_q | attack_edge;

  always_comb begin
    state_next = state;
    win_next   = win;
    if (tick && state != COMBO_IDLE) begin
      if (win == WW'(COMBO_WINDOW)) begin
        state_next = COMBO_IDLE;
        win_next   = '0;
      end else begin
        win_next = win + 1'b1;
      end
    end
    // An edge in the same clk as a window expiry is judged against the current state.
    if (attack_edge) begin
      state_next = COMBO_IDLE;
      win_next   = '0;
    end else if (left_edge) begin
      state_next = COMBO_L;
      win_next   = '0;
    end else if (down_edge) begin
      state_next = (state == COMBO_L) ? COMBO_LD : COMBO_IDLE;
      win_next   = '0;
    end else if (right_edge) begin
      state_next = (state == COMBO_LD) ? COMBO_LDR : COMBO_IDLE;
      win_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COMBO_IDLE;
      win   <= '0;
      sf_q  <= 1'b0;
      atk_q <= 1'b0;
    end else begin
      state <= state_next;
      win   <= win_next;
      sf_q  <= tick ? 1'b0 : special_fire;
      atk_q <= tick ? 1'b0 : attack_fire;
    end
  end

endmodule

// File: rtl/fighter_controller.sv
// Per-fighter pose/position engine: walk, jump physics, attack timers, combo and injury, stepped once per game tick.
// Latency: outputs (except tick) update on the clk edge following a tick cycle; button edges between ticks are held until then.
module fighter_controller
  import fighter_pkg::*;
#(
  parameter int   TICK_DIV     = 1_666_667,
  parameter int   X_INIT       = X_CENTRE,
  parameter int   X_MIN        = 8,
  parameter int   X_MAX        = SCREEN_W - 8,
  parameter int   GROUND_Y     = Y_CENTRE,
  parameter int   STEP         = 2,
  parameter int   JUMP_V       = 6,
  parameter int   PUNCH_TICKS  = 12,
  parameter int   SP_TICKS     = 24,
  parameter int   INJ_TICKS    = 16,
  parameter int   COMBO_WINDOW = 20,
  parameter logic MIRROR_INIT  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_attack,
  input  logic       hit,
  input  logic [6:0] opp_x,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic       in_air,
  output logic [1:0] move_state,
  output logic [2:0] character_state,
  output logic       mirror,
  output logic       tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0]        XMIN7   = 7'(X_MIN);
  localparam logic [6:0]        XMAX7   = 7'(X_MAX);
  localparam logic [6:0]        STEP7   = 7'(STEP);
  localparam logic [6:0]        GROUND7 = 7'(GROUND_Y);
  localparam logic signed [8:0] GROUND9 = 9'(GROUND_Y);

  logic [TW-1:0]     tick_cnt;
  logic              prev_left, prev_right, prev_down, prev_attack;
  logic              left_edge, right_edge, down_edge, attack_edge;
  logic              hit_pend, hit_now, special_fire, attack_fire;
  char_state_t       state, state_n;
  move_t             move_q, move_n;
  logic [7:0]        timer, timer_n;
  logic signed [4:0] vy, vy_n, vy_dec;
  logic signed [8:0] y_calc;
  logic [6:0]        x_n, y_n;
  logic              air_n, mir_n;

  assign tick            = (tick_cnt == TW'(TICK_DIV - 1));
  assign left_edge       = btn_left   & ~prev_left;
  assign right_edge      = btn_right  & ~prev_right;
  assign down_edge       = btn_down   & ~prev_down;
  assign attack_edge     = btn_attack & ~prev_attack;
  assign hit_now         = hit_pend | hit;
  assign character_state = state;
  assign move_state      = move_q;

  combo_detector #(.COMBO_WINDOW(COMBO_WINDOW)) u_combo (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .left_edge   (left_edge),
    .down_edge   (down_edge),
    .right_edge  (right_edge),
    .attack_edge (attack_edge),
    .special_fire(special_fire),
    .attack_fire (attack_fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      prev_left   <= 1'b0;
      prev_right  <= 1'b0;
      prev_down   <= 1'b0;
      prev_attack <= 1'b0;
      hit_pend    <= 1'b0;
    end else begin
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      prev_left   <= btn_left;
      prev_right  <= btn_right;
      prev_down   <= btn_down;
      prev_attack <= btn_attack;
      hit_pend    <= tick ? 1'b0 : hit_now;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    move_n  = MOVE_IDLE;
    x_n     = x;
    y_n     = y;
    air_n   = in_air;
    vy_n    = vy;
    mir_n   = mirror;
    vy_dec  = vy - 5'sd1;
    y_calc  = $signed({2'b00, y}) - {{4{vy[4]}}, vy};
    if (y_calc < 9'sd0) y_calc = 9'sd0;

    // Physics keeps running while airborne even if an attack or injury starts mid-jump.
    if (in_air) begin
      if (y_calc >= GROUND9 && vy_dec <= 5'sd0) begin
        y_n   = GROUND7;
        air_n = 1'b0;
        vy_n  = '0;
      end else begin
        y_n  = y_calc[6:0];
        vy_n = vy_dec;
      end
    end

    if (state == STATE_NORMAL) begin
      if (opp_x < x)      mir_n = 1'b1;
      else if (opp_x > x) mir_n = 1'b0;
    end

    if (hit_now) begin
      state_n = STATE_INJURED;
      timer_n = 8'(INJ_TICKS);
    end else if (state != STATE_NORMAL) begin
      timer_n = timer - 8'd1;
      if (timer_n == 8'd0) state_n = STATE_NORMAL;
    end else if (!in_air && (special_fire || attack_fire)) begin
      state_n = special_fire ? STATE_SP_0 : STATE_PUNCH;
      timer_n = special_fire ? 8'(SP_TICKS) : 8'(PUNCH_TICKS);
    end else begin
      if (btn_left ^ btn_right) begin
        move_n = walk_dir(btn_right, mirror);
        if (btn_right) x_n = (x > XMAX7 - STEP7) ? XMAX7 : x + STEP7;
        else           x_n = (x < XMIN7 + STEP7) ? XMIN7 : x - STEP7;
      end
      if (btn_up && !in_air) begin
        air_n = 1'b1;
        vy_n  = 5'(JUMP_V);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STATE_NORMAL;
      timer  <= '0;
      move_q <= MOVE_IDLE;
      x      <= 7'(X_INIT);
      y      <= GROUND7;
      in_air <= 1'b0;
      vy     <= '0;
      mirror <= MIRROR_INIT;
    end else if (tick) begin
      state  <= state_n;
      timer  <= timer_n;
      move_q <= move_n;
      x      <= x_n;
      y      <= y_n;
      in_air <= air_n;
      vy     <= vy_n;
      mirror <= mir_n;
    end
  end

endmodule
